// File: rtl/wb_ps2_rx_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : wb_ps2_rx_if
// Purpose  : Wishbone classic slave bus bundle for the PS/2 receiver.
// Revision : 1.0  initial release
// ============================================================================
interface wb_ps2_rx_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_ps2_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : wb_ps2_rx
// Purpose  : Wishbone PS/2 keyboard receiver with byte FIFO and level IRQ.
// Revision : 1.0  initial release
// ============================================================================
module wb_ps2_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int FIFO_AW  = 4,
    parameter int FILT_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    wb_ps2_rx_if.slave  wb,
    output logic        intr,
    input  logic        ps2_clk,
    input  logic        ps2_dat
);

    localparam int         c_depth   = 2 ** FIFO_AW;
    localparam int         c_timeout = CLK_FREQ / 500;
    localparam int         c_to_w    = $clog2(c_timeout + 1);
    localparam int         c_filt_w  = $clog2(FILT_LEN + 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_data    = 2'd1;
    localparam logic [1:0] c_parity  = 2'd2;
    localparam logic [1:0] c_stop    = 2'd3;

    localparam logic [1:0] c_reg_rxdata = 2'd0;
    localparam logic [1:0] c_reg_status = 2'd1;
    localparam logic [1:0] c_reg_ctrl   = 2'd2;

    // input conditioning
    logic [1:0]          r_clk_sync;
    logic [1:0]          r_dat_sync;
    logic                r_clk_filt;
    logic [c_filt_w-1:0] r_filt_cnt;
    logic                r_sample;
    logic                w_filt_flip;

    // receiver
    logic [1:0]          r_state;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                w_timeout;
    logic                w_done;
    logic                w_par_ok;
    logic                w_stop_ok;
    logic                w_push;
    logic                w_set_ovr;
    logic                w_set_par;
    logic                w_set_frm;

    // FIFO
    logic [7:0]          r_mem [c_depth];
    logic [FIFO_AW-1:0]  r_wptr;
    logic [FIFO_AW-1:0]  r_rptr;
    logic [FIFO_AW:0]    r_count;
    logic                w_empty;
    logic                w_full;
    logic [7:0]          w_count8;

    // bus and registers
    logic                r_ack;
    logic [31:0]         r_dat_o;
    logic                r_ovr;
    logic                r_par_err;
    logic                r_frm_err;
    logic                r_enable;
    logic                r_irq_en;
    logic                r_intr;
    logic                w_access;
    logic                w_rd;
    logic                w_wr;
    logic                w_pop;
    logic [1:0]          w_reg;
    logic [2:0]          w_clr;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_unused = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                        wb.wb_dat_i[31:5]};

    // ------------------------------------------------------------------
    // Synchronisers, glitch filter and falling-edge sample pulse
    // ------------------------------------------------------------------
    assign w_filt_flip = (r_clk_sync[1] != r_clk_filt) &&
                         (r_filt_cnt == c_filt_w'(FILT_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_sample   <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            r_sample   <= w_filt_flip & ~r_clk_sync[1];
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (w_filt_flip) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    assign w_timeout = r_enable && (r_state != c_idle) &&
                       (r_to_cnt == c_to_w'(c_timeout));
    assign w_done    = r_enable && r_sample && (r_state == c_stop) && !w_timeout;
    assign w_par_ok  = ^{r_shift, r_par};
    assign w_stop_ok = r_dat_sync[1];
    assign w_set_par = w_done & ~w_par_ok;
    assign w_set_frm = (w_done & w_par_ok & ~w_stop_ok) | w_timeout;
    // Overrun uses the pre-edge full flag, so a same-edge pop never frees a slot for this byte.
    assign w_set_ovr = w_done & w_par_ok & w_stop_ok & w_full;
    assign w_push    = w_done & w_par_ok & w_stop_ok & ~w_full;

    always_ff @(posedge clk) begin
        if (reset || !r_enable) begin
            r_state   <= c_idle;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (r_sample || r_state == c_idle) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_state <= c_idle;
            end else if (r_sample) begin
                case (r_state)
                    c_idle: begin
                        if (!r_dat_sync[1]) begin
                            r_state   <= c_data;
                            r_bit_cnt <= '0;
                        end
                    end
                    c_data: begin
                        r_shift   <= {r_dat_sync[1], r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_parity;
                        end
                    end
                    c_parity: begin
                        r_par   <= r_dat_sync[1];
                        r_state <= c_stop;
                    end
                    default: begin
                        r_state <= c_idle;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Register decode and read mux
    // ------------------------------------------------------------------
    assign w_access = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
    assign w_rd     = w_access & ~wb.wb_we_i;
    assign w_wr     = w_access & wb.wb_we_i;
    assign w_reg    = wb.wb_adr_i[3:2];
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (FIFO_AW + 1)'(c_depth));
    assign w_count8 = 8'(r_count);
    assign w_pop    = w_rd && (w_reg == c_reg_rxdata) && !w_empty;
    assign w_clr    = (w_wr && w_reg == c_reg_status) ? wb.wb_dat_i[4:2] : 3'b000;

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            c_reg_rxdata: begin
                if (!w_empty) begin
                    w_rdata[7:0] = r_mem[r_rptr];
                end
            end
            c_reg_status: begin
                w_rdata[0]    = ~w_empty;
                w_rdata[1]    = w_full;
                w_rdata[2]    = r_ovr;
                w_rdata[3]    = r_par_err;
                w_rdata[4]    = r_frm_err;
                w_rdata[15:8] = w_count8;
            end
            c_reg_ctrl: begin
                w_rdata[0] = r_enable;
                w_rdata[1] = r_irq_en;
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus handshake, flags, control and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack     <= 1'b0;
            r_dat_o   <= '0;
            r_ovr     <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_enable  <= 1'b1;
            r_irq_en  <= 1'b0;
            r_intr    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_ack   <= w_access;
            r_dat_o <= w_rd ? w_rdata : '0;
            r_intr  <= r_irq_en & ~w_empty;

            if (w_wr && w_reg == c_reg_ctrl) begin
                r_enable <= wb.wb_dat_i[0];
                r_irq_en <= wb.wb_dat_i[1];
            end

            // a same-edge set beats the write-to-clear
            r_ovr     <= (r_ovr     & ~w_clr[0]) | w_set_ovr;
            r_par_err <= (r_par_err & ~w_clr[1]) | w_set_par;
            r_frm_err <= (r_frm_err & ~w_clr[2]) | w_set_frm;

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat_o;
    assign intr        = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_wb_ps2_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_ps2_rx
// Purpose  : Self-checking bench for wb_ps2_rx against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_ps2_rx;
    localparam int CLK_FREQ = 1000000;
    localparam int TIMEOUT  = CLK_FREQ / 500;
    localparam int HALF     = 20;
    localparam int DEPTH    = 16;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic intr;

    wb_ps2_rx_if wb ();

    wb_ps2_rx #(
        .CLK_FREQ (CLK_FREQ),
        .FIFO_AW  (4),
        .FILT_LEN (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wb      (wb),
        .intr    (intr),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat)
    );

    always #10 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: received bytes in order plus the three sticky flags
    byte unsigned q[$];
    bit m_ovr = 1'b0;
    bit m_par = 1'b0;
    bit m_frm = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (q.size() != 0);
        s[1]    = (q.size() == DEPTH);
        s[2]    = m_ovr;
        s[3]    = m_par;
        s[4]    = m_frm;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    function automatic logic [31:0] model_pop();
        if (q.size() == 0) return 32'h0;
        return {24'h0, q.pop_front()};
    endfunction

    function automatic void model_frame(input byte unsigned d, input bit bad_par, input bit bad_stop);
        if (bad_par)                m_par = 1'b1;
        else if (bad_stop)          m_frm = 1'b1;
        else if (q.size() == DEPTH) m_ovr = 1'b1;
        else                        q.push_back(d);
    endfunction

    function automatic void model_clear(input logic [31:0] v);
        if (v[2]) m_ovr = 1'b0;
        if (v[3]) m_par = 1'b0;
        if (v[4]) m_frm = 1'b0;
    endfunction

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int k;
        @(posedge clk);
        #1;
        wb.wb_adr_i = adr;
        wb.wb_we_i  = we;
        wb.wb_dat_i = wdat;
        wb.wb_stb_i = 1'b1;
        wb.wb_cyc_i = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!wb.wb_ack_o && k < 8);
        check("ack", {31'b0, wb.wb_ack_o}, 32'h1);
        rdat = wb.wb_dat_o;
        wb.wb_stb_i = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        wb_xfer(adr, 1'b0, 32'h0, d);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] v);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, v, dummy);
        if (adr[3:2] == 2'd1) model_clear(v);
    endtask

    task automatic rd_fifo(input string tag, output logic [31:0] d);
        logic [31:0] e;
        e = model_pop();
        rd(32'h0, d);
        check(tag, d, e);
    endtask

    task automatic rd_status(input string tag, output logic [31:0] d);
        rd(32'h4, d);
        check(tag, d, exp_status());
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input byte unsigned d, input bit bad_par, input bit bad_stop,
                              input bit counted);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
        cyc(3 * HALF);
        if (counted) model_frame(d, bad_par, bad_stop);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        byte unsigned rb;
        int nr;
        int kind;

        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_sel_i = 4'hF;
        wb.wb_stb_i = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_we_i  = 1'b0;

        // reset values
        reset = 1'b1;
        cyc(3);
        check("rst_ack", {31'b0, wb.wb_ack_o}, 32'h0);
        check("rst_dat", wb.wb_dat_o, 32'h0);
        check("rst_intr", {31'b0, intr}, 32'h0);
        reset = 1'b0;
        cyc(2);
        rd_status("rst_status", d);
        rd(32'h8, d);
        check("rst_ctrl", d, 32'h1);
        rd(32'hC, d);
        check("reg3_read", d, 32'h0);

        // single good frame
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        rd_status("f1c_status", d);
        check("f1c_status_const", d, 32'h101);
        rd_fifo("f1c_data", d);
        check("f1c_data_const", d, 32'h1C);
        cyc(1);
        check("ack_pulse", {31'b0, wb.wb_ack_o}, 32'h0);
        rd_status("f1c_empty", d);

        // parity error
        send_frame(8'h1C, 1'b1, 1'b0, 1'b1);
        rd_status("par_status", d);
        check("par_status_const", d, 32'h08);
        wr(32'h4, 32'h08);
        rd_status("par_cleared", d);

        // fill past capacity
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        rd_status("full_status", d);
        check("full_status_const", d, 32'h1007);
        for (int i = 0; i < 17; i++) begin
            rd_fifo("full_drain", d);
            check("full_drain_const", d, (i < 16) ? 32'(i) : 32'h0);
        end
        wr(32'h4, 32'h04);
        rd_status("ovr_cleared", d);

        // timeout on a truncated frame
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        cyc(TIMEOUT + TIMEOUT / 2);
        m_frm = 1'b1;
        rd_status("to_status", d);
        check("to_status_const", d, 32'h10);
        wr(32'h4, 32'h10);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        rd_fifo("to_next", d);
        check("to_next_const", d, 32'h5A);
        rd_status("to_done", d);

        // receiver disabled
        wr(32'h8, 32'h0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        rd_status("dis_status", d);
        rd(32'h8, d);
        check("dis_ctrl", d, 32'h0);

        // interrupt
        wr(32'h8, 32'h3);
        check("irq_idle", {31'b0, intr}, 32'h0);
        send_frame(8'h29, 1'b0, 1'b0, 1'b1);
        check("irq_rise", {31'b0, intr}, 32'h1);
        rd_fifo("irq_data", d);
        check("irq_in_ack", {31'b0, intr}, 32'h1);
        cyc(1);
        check("irq_fall", {31'b0, intr}, 32'h0);

        // glitches on the clock line
        ps2_dat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ps2_clk = 1'b0;
            cyc(1);
            ps2_clk = 1'b1;
            cyc(6);
        end
        cyc(TIMEOUT + 500);
        ps2_dat = 1'b1;
        rd_status("glitch_status", d);
        check("glitch_status_const", d, 32'h0);

        // randomized frames, errors, reads and clears
        for (int it = 0; it < 30; it++) begin
            rb   = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 7);
            send_frame(rb, kind == 0, kind == 1, 1'b1);
            nr = $urandom_range(0, 2);
            for (int j = 0; j < nr; j++) rd_fifo("rnd_data", d);
            rd_status("rnd_status", d);
            check("rnd_intr", {31'b0, intr}, {31'b0, q.size() != 0});
            if ($urandom_range(0, 3) == 0) wr(32'h4, $urandom & 32'h1C);
        end

        // reset in the middle of a frame and a bus cycle
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        wb.wb_adr_i = 32'h0;
        wb.wb_we_i  = 1'b0;
        wb.wb_stb_i = 1'b1;
        wb.wb_cyc_i = 1'b1;
        reset = 1'b1;
        cyc(2);
        check("mid_rst_ack", {31'b0, wb.wb_ack_o}, 32'h0);
        check("mid_rst_dat", wb.wb_dat_o, 32'h0);
        check("mid_rst_intr", {31'b0, intr}, 32'h0);
        wb.wb_stb_i = 1'b0;
        wb.wb_cyc_i = 1'b0;
        reset = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
        cyc(2);
        rd_status("post_rst_status", d);
        rd(32'h8, d);
        check("post_rst_ctrl", d, 32'h1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        rd_fifo("post_rst_data", d);
        check("post_rst_data_const", d, 32'hA5);
        rd_status("post_rst_final", d);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
